// File: rtl/lstm_bp_pkg.sv
// Shared fixed-point constants and sequencer state encoding for the LSTM
// backprop delta engine.
package lstm_bp_pkg;

    localparam int FXP_WIDTH = 32;
    localparam int FXP_FRAC  = 24;

    localparam logic [FXP_WIDTH-1:0] ONE     = 32'd1 << FXP_FRAC;
    localparam logic [FXP_WIDTH-1:0] SAT_MAX = {1'b0, {(FXP_WIDTH-1){1'b1}}};
    localparam logic [FXP_WIDTH-1:0] SAT_MIN = {1'b1, {(FXP_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/fxp_mul_sat.sv
// Combinational signed fixed-point multiply: full-width product, floor shift
// by FRAC, then clamp (SAT=1) or wrap (SAT=0). ovf flags an out-of-range result.
module fxp_mul_sat #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 24,
    parameter int SAT   = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] p,
    output logic             ovf
);

    localparam logic signed [2*WIDTH-1:0] HI = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [2*WIDTH-1:0] LO = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    logic signed [2*WIDTH-1:0] prod;
    logic signed [2*WIDTH-1:0] shifted;
    logic                      too_hi;
    logic                      too_lo;

    assign prod    = $signed(a) * $signed(b);
    assign shifted = prod >>> FRAC;
    assign too_hi  = shifted > HI;
    assign too_lo  = shifted < LO;
    assign ovf     = too_hi || too_lo;

    always_comb begin
        p = shifted[WIDTH-1:0];
        if (SAT != 0 && too_hi) begin
            p = HI[WIDTH-1:0];
        end else if (SAT != 0 && too_lo) begin
            p = LO[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/lstm_delta_seq.sv
// Self-sequencing LSTM BPTT delta engine: 3-stage pipeline with valid/ready,
// internal per-cell recurrent delta-state (ds * f) memory and start/done FSM.
module lstm_delta_seq
    import lstm_bp_pkg::*;
#(
    parameter int WIDTH  = FXP_WIDTH,
    parameter int FRAC   = FXP_FRAC,
    parameter int CELLS  = 53,
    parameter int TSTEPS = 8,
    parameter int SAT    = 1,
    localparam int CW = $clog2(CELLS),
    localparam int TW = (TSTEPS > 1) ? $clog2(TSTEPS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_dout,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_i,
    input  logic [WIDTH-1:0] in_f,
    input  logic [WIDTH-1:0] in_o,
    input  logic [WIDTH-1:0] in_tc,
    input  logic [WIDTH-1:0] in_cprev,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_da,
    output logic [WIDTH-1:0] out_di,
    output logic [WIDTH-1:0] out_df,
    output logic [WIDTH-1:0] out_do,
    output logic [WIDTH-1:0] out_dstate,
    output logic [CW-1:0]    out_cell,
    output logic [TW-1:0]    out_step,
    output logic             out_last,
    output logic             sat_flag
);

    localparam int NA = 12;
    localparam int NB = 4;
    localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1) << FRAC;
    localparam logic [WIDTH-1:0] MAX_W = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_W = {1'b1, {(WIDTH-1){1'b0}}};

    seq_state_t state_reg, state_next;
    logic [CW-1:0] j_reg;
    logic [TW-1:0] t_reg;
    logic advance, in_fire, out_fire, start_ok, last_in, ovf_hit;

    logic             s1_valid, s1_first, s1_last;
    logic [CW-1:0]    s1_cell;
    logic [TW-1:0]    s1_step;
    logic [WIDTH-1:0] s1_pdo, s1_tc2, s1_oma2, s1_ii, s1_ff, s1_oo, s1_dtc;
    logic [WIDTH-1:0] s1_a, s1_i, s1_f, s1_cprev;

    logic             s2_valid, s2_last;
    logic [CW-1:0]    s2_cell;
    logic [TW-1:0]    s2_step;
    logic [WIDTH-1:0] s2_ds, s2_do, s2_a, s2_i, s2_cprev, s2_oma2, s2_ii, s2_ff;

    logic [WIDTH-1:0] dsf_mem [CELLS];
    logic [WIDTH-1:0] dsf_rd_reg;
    logic [WIDTH-1:0] r_comb, ds_comb;

    logic [WIDTH-1:0] pa_x [NA];
    logic [WIDTH-1:0] pa_y [NA];
    logic [WIDTH-1:0] pa_p [NA];
    logic [NA-1:0]    pa_ovf;
    logic [WIDTH-1:0] pb_x [NB];
    logic [WIDTH-1:0] pb_y [NB];
    logic [WIDTH-1:0] pb_p [NB];
    logic [NB-1:0]    pb_ovf;

    function automatic logic [WIDTH-1:0] sat_sum(input logic [WIDTH:0] s);
        if (SAT != 0 && s[WIDTH] != s[WIDTH-1]) begin
            return s[WIDTH] ? MIN_W : MAX_W;
        end
        return s[WIDTH-1:0];
    endfunction

    function automatic logic [WIDTH-1:0] add_s(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        return sat_sum({x[WIDTH-1], x} + {y[WIDTH-1], y});
    endfunction

    function automatic logic [WIDTH-1:0] sub_s(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        return sat_sum({x[WIDTH-1], x} - {y[WIDTH-1], y});
    endfunction

    // Any un-accepted result freezes every stage, so in_ready drops with it.
    assign advance  = !(out_valid && !out_ready);
    assign in_ready = (state_reg == RUN) && advance;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    assign start_ok = start && (state_reg == IDLE);
    assign last_in  = (j_reg == CW'(CELLS-1)) && (t_reg == '0);
    assign busy     = (state_reg == RUN) || (state_reg == DRAIN);
    assign done     = (state_reg == DONE);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (in_fire && last_in) state_next = DRAIN;
            DRAIN:   if (out_fire && out_last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // First-level products: operands come only from inputs or stage registers.
    always_comb begin
        pa_x[0]  = in_dout;  pa_y[0]  = in_o;
        pa_x[1]  = in_tc;    pa_y[1]  = in_tc;
        pa_x[2]  = in_a;     pa_y[2]  = in_a;
        pa_x[3]  = in_i;     pa_y[3]  = sub_s(ONE_W, in_i);
        pa_x[4]  = in_f;     pa_y[4]  = sub_s(ONE_W, in_f);
        pa_x[5]  = in_o;     pa_y[5]  = sub_s(ONE_W, in_o);
        pa_x[6]  = in_dout;  pa_y[6]  = in_tc;
        pa_x[7]  = s1_pdo;   pa_y[7]  = sub_s(ONE_W, s1_tc2);
        pa_x[8]  = s1_dtc;   pa_y[8]  = s1_oo;
        pa_x[9]  = s2_ds;    pa_y[9]  = s2_i;
        pa_x[10] = s2_ds;    pa_y[10] = s2_a;
        pa_x[11] = s2_ds;    pa_y[11] = s2_cprev;
    end

    assign r_comb  = s1_first ? '0 : dsf_rd_reg;
    assign ds_comb = add_s(pa_p[7], r_comb);

    always_comb begin
        pb_x[0] = ds_comb;   pb_y[0] = s1_f;
        pb_x[1] = pa_p[9];   pb_y[1] = s2_oma2;
        pb_x[2] = pa_p[10];  pb_y[2] = s2_ii;
        pb_x[3] = pa_p[11];  pb_y[3] = s2_ff;
    end

    generate
        for (genvar gi = 0; gi < NA; gi++) begin : g_mul_a
            fxp_mul_sat #(.WIDTH(WIDTH), .FRAC(FRAC), .SAT(SAT)) u_mul (
                .a(pa_x[gi]), .b(pa_y[gi]), .p(pa_p[gi]), .ovf(pa_ovf[gi])
            );
        end
        for (genvar gi = 0; gi < NB; gi++) begin : g_mul_b
            fxp_mul_sat #(.WIDTH(WIDTH), .FRAC(FRAC), .SAT(SAT)) u_mul (
                .a(pb_x[gi]), .b(pb_y[gi]), .p(pb_p[gi]), .ovf(pb_ovf[gi])
            );
        end
    endgenerate

    assign ovf_hit = (in_fire && (|pa_ovf[6:0]))
                  || (advance && s1_valid && ((|pa_ovf[8:7]) || pb_ovf[0]))
                  || (advance && s2_valid && ((|pa_ovf[11:9]) || (|pb_ovf[3:1])));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            j_reg     <= '0;
            t_reg     <= '0;
            sat_flag  <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (start_ok) begin
                j_reg <= '0;
                t_reg <= TW'(TSTEPS-1);
            end else if (in_fire) begin
                if (j_reg == CW'(CELLS-1)) begin
                    j_reg <= '0;
                    t_reg <= t_reg - 1'b1;
                end else begin
                    j_reg <= j_reg + 1'b1;
                end
            end
            if (start_ok) begin
                sat_flag <= 1'b0;
            end else if (SAT != 0 && ovf_hit) begin
                sat_flag <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0; s1_first <= 1'b0; s1_last <= 1'b0;
            s1_cell <= '0; s1_step <= '0;
            s1_pdo <= '0; s1_tc2 <= '0; s1_oma2 <= '0; s1_ii <= '0;
            s1_ff <= '0; s1_oo <= '0; s1_dtc <= '0;
            s1_a <= '0; s1_i <= '0; s1_f <= '0; s1_cprev <= '0;
            s2_valid <= 1'b0; s2_last <= 1'b0; s2_cell <= '0; s2_step <= '0;
            s2_ds <= '0; s2_do <= '0; s2_a <= '0; s2_i <= '0; s2_cprev <= '0;
            s2_oma2 <= '0; s2_ii <= '0; s2_ff <= '0;
            out_valid <= 1'b0; out_last <= 1'b0; out_cell <= '0; out_step <= '0;
            out_da <= '0; out_di <= '0; out_df <= '0; out_do <= '0; out_dstate <= '0;
        end else if (advance) begin
            s1_valid <= in_fire;
            s1_first <= (t_reg == TW'(TSTEPS-1));
            s1_last  <= last_in;
            s1_cell  <= j_reg;
            s1_step  <= t_reg;
            s1_pdo   <= pa_p[0];
            s1_tc2   <= pa_p[1];
            s1_oma2  <= sub_s(ONE_W, pa_p[2]);
            s1_ii    <= pa_p[3];
            s1_ff    <= pa_p[4];
            s1_oo    <= pa_p[5];
            s1_dtc   <= pa_p[6];
            s1_a     <= in_a;
            s1_i     <= in_i;
            s1_f     <= in_f;
            s1_cprev <= in_cprev;

            s2_valid <= s1_valid;
            s2_last  <= s1_last;
            s2_cell  <= s1_cell;
            s2_step  <= s1_step;
            s2_ds    <= ds_comb;
            s2_do    <= pa_p[8];
            s2_a     <= s1_a;
            s2_i     <= s1_i;
            s2_cprev <= s1_cprev;
            s2_oma2  <= s1_oma2;
            s2_ii    <= s1_ii;
            s2_ff    <= s1_ff;

            out_valid  <= s2_valid;
            out_last   <= s2_valid && s2_last;
            out_cell   <= s2_cell;
            out_step   <= s2_step;
            out_dstate <= s2_ds;
            out_do     <= s2_do;
            out_da     <= pb_p[1];
            out_di     <= pb_p[2];
            out_df     <= pb_p[3];
        end
    end

    // Recurrent store is left uninitialised; the first-step flag masks it.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            dsf_rd_reg <= dsf_mem[j_reg];
        end
        if (advance && s1_valid) begin
            dsf_mem[s1_cell] <= pb_p[0];
        end
    end

endmodule

// File: tb/tb_lstm_delta_seq.sv
// Directed bench for lstm_delta_seq (CELLS=4, TSTEPS=2): nominal, saturating,
// stalled, aborted and restarted sequences against hand-computed results.
module tb_lstm_delta_seq;

    localparam int CELLS = 4;
    localparam int TSTEPS = 2;
    localparam int CW = 2;
    localparam int TW = 1;
    localparam int NOUT = CELLS * TSTEPS;
    localparam logic [31:0] ONE  = 32'h0100_0000;
    localparam logic [31:0] HALF = 32'h0080_0000;
    localparam logic [31:0] BIG  = 32'h7F00_0000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic busy, done, in_ready, out_valid, out_last, sat_flag;
    logic in_valid = 1'b0;
    logic out_ready = 1'b1;
    logic [31:0] in_dout = '0, in_a = '0, in_i = '0, in_f = '0, in_o = '0, in_tc = '0, in_cprev = '0;
    logic [31:0] out_da, out_di, out_df, out_do, out_dstate;
    logic [CW-1:0] out_cell;
    logic [TW-1:0] out_step;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int hs_total = 0;
    int base = 0;
    int last_hs_cyc = -10;
    int mode = 0;
    bit lat_chk = 1'b1;
    int acc_cyc [NOUT];
    bit stalled_prev = 1'b0;
    logic [31:0] hold_da = '0;
    logic [CW-1:0] hold_cell = '0;
    int idx, step;

    lstm_delta_seq #(.WIDTH(32), .FRAC(24), .CELLS(CELLS), .TSTEPS(TSTEPS), .SAT(1)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_dout(in_dout), .in_a(in_a), .in_i(in_i), .in_f(in_f), .in_o(in_o),
        .in_tc(in_tc), .in_cprev(in_cprev),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_da(out_da), .out_di(out_di), .out_df(out_df), .out_do(out_do),
        .out_dstate(out_dstate), .out_cell(out_cell), .out_step(out_step),
        .out_last(out_last), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // fld: 0=dstate 1=da 2=di 3=df 4=do; mode 1 is the saturating stimulus
    function automatic logic [31:0] exp_of(input int m, input int s, input int fld);
        if (m == 1) return (fld == 4) ? 32'h8000_0000 : 32'h0000_0000;
        if (s == 1) begin
            case (fld)
                0: return 32'h0060_0000;
                1: return 32'h0024_0000;
                2: return 32'h000C_0000;
                3: return 32'h0018_0000;
                default: return 32'h0020_0000;
            endcase
        end
        case (fld)
            0: return 32'h0090_0000;
            1: return 32'h0036_0000;
            2: return 32'h0012_0000;
            3: return 32'h0024_0000;
            default: return 32'h0020_0000;
        endcase
    endfunction

    always @(negedge clk) begin
        if (rst && out_valid && !out_ready) begin
            check_val("stall_in_ready", in_ready, 0);
            if (stalled_prev) begin
                check_val("stall_hold_da", out_da, hold_da);
                check_val("stall_hold_cell", out_cell, hold_cell);
            end
            stalled_prev <= 1'b1;
            hold_da <= out_da;
            hold_cell <= out_cell;
        end else if (rst && out_valid) begin
            idx = hs_total - base;
            step = (idx < CELLS) ? 1 : 0;
            $display("out idx=%0d cell=%0d step=%0d ds=0x%08h da=0x%08h di=0x%08h df=0x%08h do=0x%08h last=%0b",
                     idx, out_cell, out_step, out_dstate, out_da, out_di, out_df, out_do, out_last);
            check_val("dstate", out_dstate, exp_of(mode, step, 0));
            check_val("da", out_da, exp_of(mode, step, 1));
            check_val("di", out_di, exp_of(mode, step, 2));
            check_val("df", out_df, exp_of(mode, step, 3));
            check_val("do", out_do, exp_of(mode, step, 4));
            check_val("cell", out_cell, idx % CELLS);
            check_val("step", out_step, step);
            check_val("last", out_last, (idx == NOUT-1) ? 1 : 0);
            if (lat_chk && idx < NOUT) check_val("latency", cyc, acc_cyc[idx] + 3);
            if (out_last) last_hs_cyc <= cyc;
            hs_total <= hs_total + 1;
            stalled_prev <= 1'b0;
        end else begin
            stalled_prev <= 1'b0;
        end
    end

    task automatic start_seq();
        base = hs_total;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check_val("start_busy", busy, 1);
    endtask

    task automatic send_range(input int n, input int m, input bit stray);
        bit got;
        for (int k = 0; k < n; k++) begin
            in_dout = (m == 1) ? BIG : ONE;
            in_o    = (m == 1) ? BIG : HALF;
            in_tc   = (m == 1) ? ONE : HALF;
            in_a = HALF; in_i = HALF; in_f = HALF; in_cprev = ONE;
            in_valid = 1'b1;
            if (stray && k == 2) start = 1'b1;
            got = 1'b0;
            for (int w = 0; w < 100 && !got; w++) begin
                @(negedge clk);
                if (in_ready) begin
                    got = 1'b1;
                    acc_cyc[k] = cyc;
                end
                @(posedge clk); #1;
            end
            $display("in  k=%0d mode=%0d accepted=%0b", k, m, got);
            check_val("accept", got, 1);
            start = 1'b0;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int nexp);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 300 && !seen; k++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check_val("done_seen", seen, 1);
        if (seen) begin
            check_val("done_busy", busy, 0);
            check_val("done_timing", cyc, last_hs_cyc + 1);
            check_val("out_count", hs_total - base, nexp);
            @(negedge clk);
            check_val("done_pulse", done, 0);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_in_ready", in_ready, 0);
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_out_last", out_last, 0);
        check_val("rst_sat_flag", sat_flag, 0);
        check_val("rst_out_da", out_da, 0);
        check_val("rst_out_cell", out_cell, 0);
        rst = 1'b1;

        // nominal sequence with latency tracking
        mode = 0; lat_chk = 1'b1;
        start_seq();
        send_range(NOUT, 0, 1'b0);
        wait_done(NOUT);
        check_val("sat_flag_nominal", sat_flag, 0);

        // saturating products
        mode = 1;
        start_seq();
        send_range(NOUT, 1, 1'b0);
        wait_done(NOUT);
        check_val("sat_flag_set", sat_flag, 1);

        // backpressure plus a stray start while busy
        mode = 0; lat_chk = 1'b0;
        start_seq();
        check_val("sat_flag_cleared", sat_flag, 0);
        fork
            send_range(NOUT, 0, 1'b1);
            begin
                repeat (6) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        wait_done(NOUT);

        // abort mid-run with asynchronous reset
        lat_chk = 1'b1;
        start_seq();
        send_range(3, 0, 1'b0);
        #2 rst = 1'b0;
        #1;
        check_val("abort_busy", busy, 0);
        check_val("abort_in_ready", in_ready, 0);
        check_val("abort_out_valid", out_valid, 0);
        check_val("abort_out_da", out_da, 0);
        check_val("abort_out_step", out_step, 0);
        check_val("abort_out_dstate", out_dstate, 0);
        @(posedge clk); #1;
        rst = 1'b1;

        // fresh run must ignore stale recurrent state
        start_seq();
        send_range(NOUT, 0, 1'b0);
        wait_done(NOUT);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
